// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the framebuffer write arbiter.
package fb_arb_pkg;

  localparam int ADDR_W    = 20;
  localparam int BRI_W     = 8;
  localparam int FB_PIXELS = 600 * 600;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [BRI_W-1:0]  bri;
    logic              swap;
  } fb_beat_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr_i.
module fb_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;

  // Rotating a doubled mask puts rr_ptr at bit 0, so priority is simply lowest bit.
  assign dbl = {elig_i, elig_i} >> rr_ptr_i;
  assign rot = dbl[N_REQ-1:0];

  always_comb begin
    any_o       = 1'b0;
    grant_idx_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_o       = 1'b1;
        grant_idx_o = IDX_W'((int'(rr_ptr_i) + k) % N_REQ);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign grant_o[gi] = any_o && (grant_idx_o == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares one framebuffer writer port among N_REQ sources with a per-frame swap barrier.
module fb_write_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 20,
  parameter int BRI_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic                    frame_go,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_hit,
  input  logic [N_REQ*BRI_W-1:0]  req_bri,
  input  logic [N_REQ-1:0]        req_swap,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    out_hit,
  output logic [BRI_W-1:0]        out_bri,
  output logic                    out_swap,
  output logic [15:0]             frame_cnt,
  output logic                    busy
);

  import fb_arb_pkg::*;

  localparam int IDX_W = fb_arb_pkg::idx_width(N_REQ);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               ov_q, ov_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               hit_q, hit_d;
  logic [BRI_W-1:0]   bri_q, bri_d;
  logic               swap_q, swap_d;
  logic               go_q, go_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [N_REQ-1:0]   elig, grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               can_load, accept, final_swap;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_hit, sel_swap;
  logic [BRI_W-1:0]   sel_bri;

  assign elig = req_valid & ~done_q;

  fb_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig_i      (elig),
    .rr_ptr_i    (rr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  assign can_load  = ~ov_q | out_ready;
  assign req_ready = (state_q == RUN && can_load) ? grant : '0;
  assign accept    = (state_q == RUN) && can_load && grant_any;

  always_comb begin
    sel_addr = '0;
    sel_hit  = 1'b0;
    sel_bri  = '0;
    sel_swap = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant[j]) begin
        sel_addr = req_addr[j*ADDR_W +: ADDR_W];
        sel_hit  = req_hit[j];
        sel_bri  = req_bri[j*BRI_W +: BRI_W];
        sel_swap = req_swap[j];
      end
    end
  end

  // A swap is final only when every other requester has already finished.
  assign final_swap = sel_swap & (&(done_q | grant));

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    rr_d    = rr_q;
    ov_d    = ov_q;
    addr_d  = addr_q;
    hit_d   = hit_q;
    bri_d   = bri_q;
    swap_d  = swap_q;
    go_d    = 1'b0;
    cnt_d   = cnt_q;

    if (ov_q && out_ready) begin
      ov_d   = 1'b0;
      swap_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          go_d    = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          ov_d   = 1'b1;
          addr_d = sel_addr;
          hit_d  = sel_hit;
          bri_d  = sel_bri;
          swap_d = final_swap;
          done_d = done_q | (grant & {N_REQ{sel_swap}});
          rr_d   = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
          if (final_swap) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (can_load) begin
          done_d = '0;
          cnt_d  = cnt_q + 16'd1;
          if (enable) begin
            state_d = RUN;
            go_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= '0;
      rr_q    <= '0;
      ov_q    <= 1'b0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      bri_q   <= '0;
      swap_q  <= 1'b0;
      go_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rr_q    <= rr_d;
      ov_q    <= ov_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      bri_q   <= bri_d;
      swap_q  <= swap_d;
      go_q    <= go_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frame_go  = go_q;
  assign out_valid = ov_q;
  assign out_addr  = addr_q;
  assign out_hit   = hit_q;
  assign out_bri   = bri_q;
  assign out_swap  = swap_q;
  assign frame_cnt = cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomised bench for fb_write_arbiter with a behavioural frame/arbitration model.
module tb_fb_write_arbiter;

  import fb_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 20;
  localparam int BW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic            frame_go;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_hit;
  logic [N*BW-1:0] req_bri;
  logic [N-1:0]    req_swap;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_addr;
  logic            out_hit;
  logic [BW-1:0]   out_bri;
  logic            out_swap;
  logic [15:0]     frame_cnt;
  logic            busy;

  always #5 clk = ~clk;

  fb_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .BRI_W(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .frame_go  (frame_go),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_hit   (req_hit),
    .req_bri   (req_bri),
    .req_swap  (req_swap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_hit   (out_hit),
    .out_bri   (out_bri),
    .out_swap  (out_swap),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Stimulus controls
  int fixed_len[N];
  int pv       = 100;
  int rdy_mode = 0;
  bit log_en   = 1'b0;

  // Requester behaviour: wait for frame_go, send len beats, last one carries swap.
  initial begin
    logic         go_s;
    logic [N-1:0] acc_s;
    bit           active[N];
    int           sent[N];
    int           len[N];
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0;
      sent[i]   = 0;
      len[i]    = 1;
    end
    req_valid = '0;
    req_addr  = '0;
    req_hit   = '0;
    req_bri   = '0;
    req_swap  = '0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      go_s  = frame_go;
      acc_s = req_valid & req_ready;
      #1;
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          active[i]    = 1'b0;
          req_valid[i] = 1'b0;
          continue;
        end
        if (acc_s[i]) begin
          sent[i]++;
          if (req_swap[i]) active[i] = 1'b0;
          req_valid[i] = 1'b0;
        end
        if (go_s) begin
          active[i] = 1'b1;
          sent[i]   = 0;
          len[i]    = (fixed_len[i] != 0) ? fixed_len[i] : int'($urandom_range(1, 12));
        end
        if (active[i] && !req_valid[i] && int'($urandom_range(1, 100)) <= pv) begin
          req_valid[i]         = 1'b1;
          req_addr[i*AW +: AW] = AW'($urandom_range(0, FB_PIXELS - 1));
          req_bri[i*BW +: BW]  = BW'($urandom);
          req_hit[i]           = 1'($urandom_range(0, 1));
          req_swap[i]          = (sent[i] == len[i] - 1);
        end
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(out_valid && out_swap);
      endcase
    end
  end

  // Behavioural model state
  int           m_st;        // 0 idle, 1 running a frame, 2 waiting for final beat to leave
  logic [N-1:0] m_done;
  int           m_rr;
  bit           m_ov;
  fb_beat_t     m_beat;
  bit           m_go;
  int           m_cnt;
  fb_beat_t     sb[$];
  logic [N-1:0] grant_log[$];
  int           frame_swaps, frame_beats, last_frame_beats, prev_cnt, go_count;

  task automatic model_reset();
    m_st        = 0;
    m_done      = '0;
    m_rr        = 0;
    m_ov        = 1'b0;
    m_beat      = '0;
    m_go        = 1'b0;
    m_cnt       = 0;
    sb.delete();
    frame_swaps = 0;
    frame_beats = 0;
    prev_cnt    = 0;
  endtask

  initial begin
    int           g;
    int           j;
    logic [N-1:0] exp_rdy;
    fb_beat_t     b;
    fb_beat_t     exp_b;
    bit           all_oth;
    int           n_st, n_rr, n_cnt;
    logic [N-1:0] n_done;
    bit           n_ov, n_go;
    fb_beat_t     n_beat;
    go_count = 0;
    last_frame_beats = 0;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        continue;
      end
      exp_rdy = '0;
      g = -1;
      if (m_st == 1 && (!m_ov || out_ready)) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (g < 0 && req_valid[j] && !m_done[j]) g = j;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;

      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("frame_go", 32'(frame_go), 32'(m_go));
      chk("busy", 32'(busy), 32'(m_st != 0));
      chk("frame_cnt", 32'(frame_cnt), 32'(16'(m_cnt)));
      if (m_ov) begin
        chk("out_addr", 32'(out_addr), 32'(m_beat.addr));
        chk("out_hit", 32'(out_hit), 32'(m_beat.hit));
        chk("out_bri", 32'(out_bri), 32'(m_beat.bri));
        chk("out_swap", 32'(out_swap), 32'(m_beat.swap));
      end
      if (log_en && req_ready != '0) grant_log.push_back(req_ready);
      if (frame_go) go_count++;

      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_beat", 32'(out_addr), 32'hFFFF_FFFF);
        end else begin
          exp_b = sb.pop_front();
          chk("sb_addr", 32'(out_addr), 32'(exp_b.addr));
          chk("sb_bri", 32'(out_bri), 32'(exp_b.bri));
        end
        frame_beats++;
        if (out_swap) frame_swaps++;
      end
      if (32'(frame_cnt) != 32'(16'(prev_cnt))) begin
        chk("swaps_per_frame", 32'(frame_swaps), 32'd1);
        $display("frame %0d complete: %0d beats, %0d swap", frame_cnt, frame_beats, frame_swaps);
        last_frame_beats = frame_beats;
        frame_swaps = 0;
        frame_beats = 0;
        prev_cnt = int'(frame_cnt);
      end

      n_st = m_st; n_rr = m_rr; n_cnt = m_cnt; n_done = m_done;
      n_ov = m_ov; n_beat = m_beat; n_go = 1'b0;
      if (m_ov && out_ready) n_ov = 1'b0;
      case (m_st)
        0: if (enable) begin n_st = 1; n_go = 1'b1; end
        1: if (g >= 0) begin
          all_oth = 1'b1;
          for (int k = 0; k < N; k++) if (k != g && !m_done[k]) all_oth = 1'b0;
          b.addr = req_addr[g*AW +: AW];
          b.hit  = req_hit[g];
          b.bri  = req_bri[g*BW +: BW];
          b.swap = req_swap[g] && all_oth;
          n_ov   = 1'b1;
          n_beat = b;
          sb.push_back(b);
          if (req_swap[g]) n_done[g] = 1'b1;
          n_rr = (g + 1) % N;
          if (b.swap) n_st = 2;
        end
        default: if (!m_ov || out_ready) begin
          n_ov   = 1'b0;
          n_done = '0;
          n_cnt  = (m_cnt + 1) % 65536;
          if (enable) begin n_st = 1; n_go = 1'b1; end
          else n_st = 0;
        end
      endcase

      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_st = n_st; m_rr = n_rr; m_cnt = n_cnt; m_done = n_done;
        m_ov = n_ov; m_beat = n_beat; m_go = n_go;
      end
    end
  end

  task automatic wait_frames(input int target, input string name);
    bit hit_t;
    hit_t = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk); #1;
      if (int'(frame_cnt) == target) begin
        hit_t = 1'b1;
        break;
      end
    end
    if (!hit_t) chk(name, 32'(frame_cnt), 32'(target));
  endtask

  initial begin
    int  cnt0;
    int  go0;
    bit  seen;
    fixed_len[0] = 0;
    fixed_len[1] = 0;

    // Reset state
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_go", 32'(frame_go), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_req_ready", 32'(req_ready), 32'd0);

    // Directed frame: req0 swaps on beat 10, req1 on beat 20
    fixed_len[0] = 10;
    fixed_len[1] = 20;
    pv = 100;
    rdy_mode = 0;
    log_en = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("go_pulse", 32'(frame_go), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    wait_frames(1, "timeout_frame1");
    chk("frame1_beats", 32'(last_frame_beats), 32'd30);
    chk("go_after_drain", 32'(frame_go), 32'd1);
    log_en = 1'b0;
    if (grant_log.size() < 4) begin
      chk("grant_log_len", 32'(grant_log.size()), 32'd4);
    end else begin
      chk("grant_0", 32'(grant_log[0]), 32'd1);
      chk("grant_1", 32'(grant_log[1]), 32'd2);
      chk("grant_2", 32'(grant_log[2]), 32'd1);
      chk("grant_3", 32'(grant_log[3]), 32'd2);
    end

    // Randomised frames with 50% writer back-pressure
    fixed_len[0] = 0;
    fixed_len[1] = 0;
    pv = 60;
    rdy_mode = 1;
    wait_frames(7, "timeout_random");

    // Drop enable mid-frame
    fixed_len[0] = 8;
    fixed_len[1] = 5;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (frame_go) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("timeout_go_wait", 32'(frame_go), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b0;
    cnt0 = int'(frame_cnt);
    @(negedge clk); #1;
    go0 = go_count;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("timeout_idle", 32'(busy), 32'd0);
    chk("drop_frame_done", 32'(frame_cnt), 32'(cnt0 + 1));
    repeat (20) @(posedge clk);
    #1;
    chk("drop_stays_idle", 32'(busy), 32'd0);
    chk("drop_no_go", 32'(go_count), 32'(go0));
    chk("drop_cnt_held", 32'(frame_cnt), 32'(cnt0 + 1));

    // Reset while the final beat is stalled in FLUSH
    fixed_len[0] = 3;
    fixed_len[1] = 4;
    pv = 100;
    rdy_mode = 2;
    enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (out_valid && out_swap) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("timeout_flush", 32'(out_swap), 32'd1);
    chk("flush_busy", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_swap", 32'(out_swap), 32'd0);
    chk("arst_out_addr", 32'(out_addr), 32'd0);
    chk("arst_out_bri", 32'(out_bri), 32'd0);
    chk("arst_out_hit", 32'(out_hit), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    enable = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cnt", 32'(frame_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Restart from IDLE
    fixed_len[0] = 0;
    fixed_len[1] = 0;
    pv = 80;
    enable = 1'b1;
    wait_frames(1, "timeout_restart");
    chk("restart_cnt", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Sequences and shares the single framebuffer writer port among `N_REQ` pixel-write sources, such as renderers and test-pattern generators that emit addr/hit/bri/swap beats.
- Grants sources round-robin through a one-entry output register.
- Imposes a frame barrier: the writer sees exactly one `swap` per frame, only after every source has finished its frame.
- Issues the per-frame `go` pulse that starts all sources together.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, 1..8.
- `ADDR_W`, 20: framebuffer address width (600×600 fits).
- `BRI_W`, 8: brightness width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: level; run frames while high.
- `frame_go` out 1: one-cycle pulse starting a frame for all requesters.
- `req_valid` in N_REQ: per-requester beat valid.
- `req_ready` out N_REQ: per-requester beat accepted when valid&ready.
- `req_addr` in N_REQ×ADDR_W: packed, requester i at [i*ADDR_W +: ADDR_W].
- `req_hit` in N_REQ: hit flag per requester.
- `req_bri` in N_REQ×BRI_W: packed brightness.
- `req_swap` in N_REQ: marks requester's last beat of frame.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: writer accepts beat.
- `out_addr` out ADDR_W, `out_hit` out 1, `out_bri` out BRI_W: forwarded beat.
- `out_swap` out 1: buffer swap; set only on frame's final beat.
- `frame_cnt` out 16: frames completed, wraps at 2^16.
- `busy` out 1: state != IDLE.

## Operation
FSM states are IDLE, RUN and FLUSH.
- IDLE: `req_ready`=0. When `enable`=1, go to RUN and pulse `frame_go` in the same cycle as the transition.
- RUN: arbitrate among requesters with `req_valid`=1 and done-bit=0.
  - Grant is round-robin, starting from `rr_ptr`.
  - A grant occurs only when the output register is empty or being drained this cycle (`out_valid & out_ready`).
  - At most one `req_ready` bit is high per cycle: the granted one, combinationally.
- Acceptance of a beat:
  - The beat loads the output register.
  - `rr_ptr` becomes (granted+1) mod N_REQ.
  - If `req_swap`=1, the requester's done-bit is set.
- `out_swap`:
  - `out_swap` = `req_swap` AND (all other done-bits already set).
  - Earlier finishers' swap beats are forwarded as pixels with `out_swap`=0.
  - When the final swap beat is accepted, go to FLUSH.
- FLUSH:
  - `req_ready`=0.
  - When the output register drains, clear the done mask and increment `frame_cnt`.
  - If `enable`=1: go to RUN and pulse `frame_go`. Otherwise go to IDLE.
- `enable` falling mid-frame has no effect until the frame completes.
- Done requesters hold `req_ready`=0 for the rest of the frame.
- `N_REQ`=1: every swap beat is final.

## Timing
- Reset values:
  - Outputs: `out_valid`=0, `out_swap`=0, `out_addr`/`out_bri`/`out_hit`=0, `frame_go`=0, `frame_cnt`=0, `busy`=0, `req_ready`=0.
  - Internal: `rr_ptr`=0, done mask=0, state IDLE.
- Latency is 1 cycle, from acceptance (req_valid&req_ready at edge k) to `out_valid` at k+1.
- Throughput is 1 beat/cycle while `out_ready`=1.
- Output holds stable while `out_valid`=1 and `out_ready`=0.
- `frame_go` is registered and asserted the cycle after the IDLE/FLUSH exit condition. Requesters must not see ready before `frame_go` has pulsed.
- Reset asserted mid-frame drops `out_valid` immediately (async) and discards the in-flight beat.

## Structure
- Package `fb_arb_pkg` holds:
  - `state_t` enum {IDLE, RUN, FLUSH}.
  - `fb_beat_t` struct {addr, hit, bri, swap}, parameterised through localparams ADDR_W=20, BRI_W=8.
  - `FB_PIXELS` = 600*600.
- Sub-module `fb_rr_pick`:
  - Combinational round-robin picker.
  - Inputs: eligible mask and `rr_ptr`.
  - Outputs: one-hot grant and grant index.
- The top level holds the FSM, done mask, output register and counter.

## Test plan
- Reset, `enable`=1 → `frame_go` pulses once; `busy`=1; `req_ready`=0 during IDLE.
- N_REQ=2, both valid continuously with `out_ready`=1 → grants alternate 0,1,0,1; output at 1 beat/cycle with 1-cycle latency.
- Req0 swaps at beat 10, req1 at beat 20:
  - Req0 swap beat shows `out_swap`=0 and `req_ready[0]` stays 0 afterwards.
  - Req1 swap beat shows `out_swap`=1; `frame_cnt`=1; next `frame_go` follows the drain.
- `out_ready` toggled randomly (50%) → no beat lost or duplicated; output stable while stalled; scoreboard matches addr/bri.
- `enable` dropped mid-frame → frame completes with one `out_swap`, FSM to IDLE, no further `frame_go`.
- `rst_n` asserted during FLUSH with `out_valid`=1 → all outputs zero asynchronously; after release, restart from IDLE with `frame_cnt`=0.
